// File: rtl/imm_ext_arbiter_if.sv
// Bundle of requester, extender and response signals for the immediate-extender arbiter.
// The arbiter is the slave (serves requests); the environment side is the master.
interface imm_ext_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             r0_valid;
  logic             r0_ready;
  logic [31:0]      r0_in;
  logic [1:0]       r0_sel;
  logic             r0_zext;
  logic             r1_valid;
  logic             r1_ready;
  logic [31:0]      r1_in;
  logic [1:0]       r1_sel;
  logic             r1_zext;
  logic [31:0]      ext_in;
  logic [1:0]       ext_sel;
  logic             ext_enable;
  logic [31:0]      ext_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  r0_valid, r0_in, r0_sel, r0_zext,
    input  r1_valid, r1_in, r1_sel, r1_zext,
    input  ext_y, rsp_ready,
    output r0_ready, r1_ready, ext_in, ext_sel, ext_enable,
    output rsp_valid, rsp_data, rsp_id, cnt0, cnt1
  );

  modport master (
    output r0_valid, r0_in, r0_sel, r0_zext,
    output r1_valid, r1_in, r1_sel, r1_zext,
    output ext_y, rsp_ready,
    input  r0_ready, r1_ready, ext_in, ext_sel, ext_enable,
    input  rsp_valid, rsp_data, rsp_id, cnt0, cnt1
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin sharing of one immediate extender between decode (0) and branch-target (1),
// with a one-entry result register that can drain and refill on the same edge.
//   state   | meaning
//   S_EMPTY | result register holds nothing
//   S_FULL  | result register holds a result for the consumer
module imm_ext_arbiter #(
  parameter logic FIRST_PRIO = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  imm_ext_arbiter_if.slave    bus
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_id;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_any;
  logic             w_gnt;
  logic             w_slot_free;
  logic             w_accept;

  always_comb begin
    w_any       = bus.r0_valid | bus.r1_valid;
    // On contention the requester that did not win last time goes first.
    w_gnt       = (bus.r0_valid & bus.r1_valid) ? ~r_last_grant : bus.r1_valid;
    w_slot_free = (r_state == S_EMPTY) | bus.rsp_ready;
    w_accept    = w_slot_free & w_any & ~reset;
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (bus.rsp_ready & ~w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_EMPTY;
      r_last_grant <= ~FIRST_PRIO;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_data   <= bus.ext_y;
        r_rsp_id     <= w_gnt;
        r_last_grant <= w_gnt;
        if (!w_gnt && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
        if (w_gnt && (r_cnt1 != '1))  r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  assign bus.r0_ready   = w_accept & ~w_gnt;
  assign bus.r1_ready   = w_accept & w_gnt;
  // Extender sees the winner even when the slot is busy, so ext_y is ready the moment it frees.
  assign bus.ext_in     = !w_any ? 32'd0 : (w_gnt ? bus.r1_in   : bus.r0_in);
  assign bus.ext_sel    = !w_any ? 2'd0  : (w_gnt ? bus.r1_sel  : bus.r0_sel);
  assign bus.ext_enable = !w_any ? 1'b0  : (w_gnt ? bus.r1_zext : bus.r0_zext);
  assign bus.rsp_valid  = (r_state == S_FULL);
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: two instances (8-bit and 2-bit counters) driven identically,
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1, z0, z1, rr;
  logic [31:0] in0, in1;
  logic [1:0]  sel0, sel1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one-entry result slot, raw (unsaturated) accept counts, last winner.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic        m_id    = 1'b0;
  logic        m_last  = 1'b1;
  int          m_n0    = 0;
  int          m_n1    = 0;

  imm_ext_arbiter_if #(.CNT_W(8)) ifa ();
  imm_ext_arbiter_if #(.CNT_W(2)) ifb ();

  imm_ext_arbiter #(.FIRST_PRIO(1'b0), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  imm_ext_arbiter #(.FIRST_PRIO(1'b0), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  always #5 clk = ~clk;

  // Reference extender: 00 imm8, 01 imm12, 10 imm24, 11 split imm8 {in[11:8],in[3:0]}.
  function automatic logic [31:0] ext_fn(input logic [31:0] x, input logic [1:0] s, input logic z);
    logic [31:0] raw;
    int w;
    case (s)
      2'd0:    begin raw = {24'd0, x[7:0]};            w = 8;  end
      2'd1:    begin raw = {20'd0, x[11:0]};           w = 12; end
      2'd2:    begin raw = {8'd0, x[23:0]};            w = 24; end
      default: begin raw = {24'd0, x[11:8], x[3:0]};   w = 8;  end
    endcase
    raw = raw << (32 - w);
    return z ? (raw >> (32 - w)) : 32'($signed(raw) >>> (32 - w));
  endfunction

  assign ifa.r0_valid = v0;   assign ifb.r0_valid = v0;
  assign ifa.r0_in    = in0;  assign ifb.r0_in    = in0;
  assign ifa.r0_sel   = sel0; assign ifb.r0_sel   = sel0;
  assign ifa.r0_zext  = z0;   assign ifb.r0_zext  = z0;
  assign ifa.r1_valid = v1;   assign ifb.r1_valid = v1;
  assign ifa.r1_in    = in1;  assign ifb.r1_in    = in1;
  assign ifa.r1_sel   = sel1; assign ifb.r1_sel   = sel1;
  assign ifa.r1_zext  = z1;   assign ifb.r1_zext  = z1;
  assign ifa.rsp_ready = rr;  assign ifb.rsp_ready = rr;
  assign ifa.ext_y = ext_fn(ifa.ext_in, ifa.ext_sel, ifa.ext_enable);
  assign ifb.ext_y = ext_fn(ifb.ext_in, ifb.ext_sel, ifb.ext_enable);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Who the arbiter picks from the current requests: -1 none, else requester index.
  function automatic int pick();
    if (v0 && v1) return m_last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic int taken();
    int p;
    p = pick();
    if (p < 0 || reset) return -1;
    if (m_valid && !rr) return -1;
    return p;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  always @(posedge clk) begin
    int t;
    t = taken();
    if (reset) begin
      m_valid <= 1'b0; m_data <= '0; m_id <= 1'b0; m_last <= 1'b1; m_n0 <= 0; m_n1 <= 0;
    end else if (t >= 0) begin
      m_valid <= 1'b1;
      m_id    <= t[0];
      m_last  <= t[0];
      m_data  <= (t == 0) ? ext_fn(in0, sel0, z0) : ext_fn(in1, sel1, z1);
      if (t == 0) m_n0 <= m_n0 + 1; else m_n1 <= m_n1 + 1;
    end else if (m_valid && rr) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    int p, t;
    logic [31:0] e_in;
    logic [1:0]  e_sel;
    logic        e_en;
    p = pick();
    t = taken();
    e_in  = (p == 0) ? in0  : (p == 1) ? in1  : 32'd0;
    e_sel = (p == 0) ? sel0 : (p == 1) ? sel1 : 2'd0;
    e_en  = (p == 0) ? z0   : (p == 1) ? z1   : 1'b0;
    chk("r0_ready",   {31'd0, ifa.r0_ready},   {31'd0, t == 0});
    chk("r1_ready",   {31'd0, ifa.r1_ready},   {31'd0, t == 1});
    chk("ext_in",     ifa.ext_in,              e_in);
    chk("ext_sel",    {30'd0, ifa.ext_sel},    {30'd0, e_sel});
    chk("ext_enable", {31'd0, ifa.ext_enable}, {31'd0, e_en});
    chk("rsp_valid",  {31'd0, ifa.rsp_valid},  {31'd0, m_valid});
    chk("rsp_data",   ifa.rsp_data,            m_data);
    chk("rsp_id",     {31'd0, ifa.rsp_id},     {31'd0, m_id});
    chk("cnt0_w8",    {24'd0, ifa.cnt0},       sat(m_n0, 255));
    chk("cnt1_w8",    {24'd0, ifa.cnt1},       sat(m_n1, 255));
    chk("cnt0_w2",    {30'd0, ifb.cnt0},       sat(m_n0, 3));
    chk("cnt1_w2",    {30'd0, ifb.cnt1},       sat(m_n1, 3));
    chk("b_rsp_data", ifb.rsp_data,            m_data);
    chk("b_ready",    {30'd0, ifb.r1_ready, ifb.r0_ready}, {30'd0, t == 1, t == 0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a0, input logic a1, input logic ready);
    v0 = a0; v1 = a1; rr = ready;
    in0 = $urandom; in1 = $urandom;
    sel0 = 2'($urandom_range(0, 3)); sel1 = 2'($urandom_range(0, 3));
    z0 = 1'($urandom_range(0, 1)); z1 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    #1;
    chk("lit_rst_ready", {30'd0, ifa.r1_ready, ifa.r0_ready}, 32'd0);
    tick();
    chk("lit_rst_ready2", {30'd0, ifa.r1_ready, ifa.r0_ready}, 32'd0);
    tick();
    chk("lit_rst_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("lit_rst_cnt", {16'd0, ifa.cnt1, ifa.cnt0}, 32'd0);

    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    in0 = 32'h0000_0080; sel0 = 2'b00; z0 = 1'b0;
    #1;
    chk("lit_r0_ready", {31'd0, ifa.r0_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("lit_r0_valid", {31'd0, ifa.rsp_valid}, 32'd1);
    chk("lit_r0_data", ifa.rsp_data, 32'hFFFF_FF80);
    chk("lit_r0_id", {31'd0, ifa.rsp_id}, 32'd0);
    chk("lit_r0_cnt0", {24'd0, ifa.cnt0}, 32'd1);

    // Both requesters every cycle from a fresh reset: 0,1,0,1,0,1.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      #1;
      chk("lit_alt_grant", {31'd0, ifa.r1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("lit_alt_cnt0", {24'd0, ifa.cnt0}, 32'd3);
    chk("lit_alt_cnt1", {24'd0, ifa.cnt1}, 32'd3);
    chk("lit_alt_id", {31'd0, ifa.rsp_id}, 32'd1);

    // Backpressure with r1 waiting, then drain+accept on one edge.
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      #1;
      chk("lit_bp_r1_ready", {31'd0, ifa.r1_ready}, 32'd0);
      chk("lit_bp_id", {31'd0, ifa.rsp_id}, 32'd1);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1);
    #1;
    chk("lit_drain_r1_ready", {31'd0, ifa.r1_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("lit_drain_valid", {31'd0, ifa.rsp_valid}, 32'd1);
    chk("lit_drain_cnt1", {24'd0, ifa.cnt1}, 32'd4);

    // Five r0 accepts: 2-bit counter saturates at 3, 8-bit reaches 5.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("lit_sat_w2", {30'd0, ifb.cnt0}, 32'd3);
    chk("lit_sat_w8", {24'd0, ifa.cnt0}, 32'd5);

    // Reset while FULL and stalled.
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    #1;
    chk("lit_mid_rst_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    chk("lit_mid_rst_cnt", {24'd0, ifa.cnt0}, 32'd0);
    chk("lit_mid_rst_prio", {31'd0, ifa.r0_ready}, 32'd1);
    tick();

    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
